rng_arbiter: RTL and testbench
==============================

# rng_arbiter

Scheduler that shares the single free-running random source (the LFSR-backed TRNG, widened to an enable-driven source) between `NREQ` requesters. It owns the source's advance enable and runs a post-reset warm-up that discards words. It grants requests round-robin and guarantees that no word is ever delivered twice. It also runs a repetition-count health test that latches a sticky failure. It sits between the TRNG and the per-core/per-agent consumers (seed CSR, cache randomised replacement, etc.).

## Interface
- `NREQ`, 4: number of requesters, ≥2.
- `DBITS`, 64: random word width.
- `WARMUP`, 16: number of source words discarded after reset; 0 allowed.
- `clock`  in  1  sole clock; all logic on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `rng_data`  in  DBITS  current source word, combinational, stable until advanced.
- `rng_enable`  out  1  advance source at this edge; word on `rng_data` is consumed.
- `req`  in  NREQ  level request per requester; may drop at any time before grant.
- `rsp_valid`  out  NREQ  registered one-hot pulse: word delivered to that requester.
- `rsp_data`  out  DBITS  registered word, valid when any `rsp_valid` bit set.
- `ready`  out  1  registered; 1 while in RUN.
- `error`  out  1  registered; sticky health-test failure.

## Operation
- States: WARMUP → RUN → FAIL. Reset enters WARMUP, or RUN if `WARMUP`==0.
- WARMUP: `rng_enable`=1 every cycle. The down-counter (reset to `WARMUP`) decrements per advance. After the `WARMUP`-th advance, go to RUN. `req` is ignored; no grants.
- RUN: if any `req` bit is set, pick winner w = first set bit at or after `ptr` (cyclic). The same cycle:
  - `rng_enable`=1.
  - Next edge: `rsp_data`<=`rng_data`, `rsp_valid`<=onehot(w), `ptr`<=(w+1) mod NREQ.
  - With no `req`, `rng_enable`=0 and `rsp_valid`<=0.
- Health test: `last_word` register captures `rng_data` on every advance (warm-up included). If `rng_data`==`last_word` at the moment of an advance:
  - The word is not delivered and `rsp_valid` stays 0.
  - State goes to FAIL, and `error`<=1 next edge.
  - This applies in WARMUP too.
- FAIL: `rng_enable`=0, `rsp_valid`=0, `ready`=0, `error`=1. The block leaves FAIL only on reset.
- Each advance consumes exactly one word; a word is delivered to at most one requester.
- A held `req` bit is served again after the other active requesters have been served (fair RR). The worst-case wait in RUN is NREQ cycles.

## Timing
- Reset values:
  - `rsp_valid`=0, `rsp_data`=0, `ready`=0, `error`=0, `rng_enable`=0 while `reset_n` low.
  - `ptr`=0, `last_word`=0, counter=`WARMUP`.
- `rng_enable` is a combinational function of state, `req`, `rng_data` and `last_word`. It is not registered.
- Grant latency: `req` high in a RUN cycle t → `rsp_valid` at t+1. Throughput is one word per cycle.
- `ready` rises the edge after the last warm-up advance. The first grant can be decided in that same `ready`-high cycle.
- `req` dropped in cycle t means no grant decided in t. A bit dropped the cycle `rsp_valid` arrives receives nothing further.
- Async reset mid-stream clears outputs immediately. Warm-up restarts on release. The source itself is not reset by this block.

## Structure
- Package `rng_arb_pkg`: state enum (WARMUP/RUN/FAIL) and the LFSR tap constant 64'hD800_0000_0000_0000 for bench models.
- Sub-module `rng_rr_pick`: combinational round-robin picker (`req`, `ptr` → one-hot grant, index, any).
- Top: FSM, warm-up counter, `ptr`, `last_word`, output registers. Target ~200 lines.

## Test plan
All scenarios use NREQ=4, DBITS=64, WARMUP=4 and a behavioural 64-bit LFSR (taps above, init all-ones).
- Release reset, `req`=0 → `rng_enable` high exactly 4 cycles, `ready`=1 in cycle 5, `rsp_valid` never set.
- `req`=4'b0001 held in RUN → `rsp_valid`=4'b0001 every cycle, `rsp_data` equals successive LFSR words 5, 6, 7… with no repeats.
- `req`=4'b1111 held for 8 grants → winners 0,1,2,3,0,1,2,3, one word per cycle, all distinct.
- `req`=4'b0100 asserted during warm-up → no grant before `ready`; first `rsp_valid`=4'b0100 the cycle after `ready` rises; `ptr`=3 afterwards.
- Force `rng_data`=64'h5 constant, `req`=4'b0010 → first advance delivers 64'h5; the second advance gives `error`=1, `ready`=0, `rng_enable`=0, and no further `rsp_valid` until reset.
- Pulse `reset_n` low mid-stream with `req`=4'b1111 → all outputs 0 immediately; 4 warm-up advances follow release; grants resume at requester 0.

Source files
------------

// File: rtl/rng_arb_pkg.sv
// Shared types and constants for the random-source arbiter.
package rng_arb_pkg;

  typedef enum logic [1:0] {
    ST_WARMUP = 2'd0,
    ST_RUN    = 2'd1,
    ST_FAIL   = 2'd2
  } arb_state_t;

  // Feedback taps of the 64-bit Galois LFSR behind the TRNG source.
  localparam logic [63:0] LFSR_TAPS = 64'hD800_0000_0000_0000;

  // Bits needed to index n items. Never less than 1.
  function automatic int unsigned width_of(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rng_rr_pick.sv
// Combinational round-robin picker.
// Returns the first set request at or after ptr, searching cyclically.
module rng_rr_pick
  import rng_arb_pkg::*;
#(
  parameter  int NREQ = 4,
  localparam int PW   = width_of(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] grant,
  output logic [PW-1:0]   index,
  output logic            any
);

  logic [PW-1:0] cand;

  // Walk the requesters starting at ptr and keep the first one found.
  always_comb begin
    grant = '0;
    index = '0;
    any   = 1'b0;
    cand  = '0;
    for (int off = 0; off < NREQ; off++) begin
      cand = PW'((int'(ptr) + off) % NREQ);
      if (!any && req[cand]) begin
        any         = 1'b1;
        index       = cand;
        grant[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rng_arbiter.sv
// Shares one enable-driven random source between NREQ requesters.
// Discards WARMUP words after reset, then grants round-robin with one word per
// grant. A word equal to the previously consumed one trips a sticky failure.
module rng_arbiter
  import rng_arb_pkg::*;
#(
  parameter  int NREQ   = 4,
  parameter  int DBITS  = 64,
  parameter  int WARMUP = 16,
  localparam int PW     = width_of(NREQ),
  localparam int CW     = width_of(WARMUP + 1)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [DBITS-1:0] rng_data,
  output logic             rng_enable,
  input  logic [NREQ-1:0]  req,
  output logic [NREQ-1:0]  rsp_valid,
  output logic [DBITS-1:0] rsp_data,
  output logic             ready,
  output logic             error
);

  localparam arb_state_t    RESET_STATE = (WARMUP == 0) ? ST_RUN : ST_WARMUP;
  localparam logic [CW-1:0] WARM_INIT   = CW'(WARMUP);

  arb_state_t       state;
  arb_state_t       state_next;
  logic [CW-1:0]    warm_cnt;
  logic [PW-1:0]    ptr;
  logic [PW-1:0]    ptr_after;
  logic [DBITS-1:0] last_word;
  logic [NREQ-1:0]  grant;
  logic [PW-1:0]    pick_index;
  logic             pick_any;
  logic             is_repeat;
  logic             deliver;

  rng_rr_pick #(
    .NREQ (NREQ)
  ) u_pick (
    .req   (req),
    .ptr   (ptr),
    .grant (grant),
    .index (pick_index),
    .any   (pick_any)
  );

  // The health test compares the word being consumed with the last consumed word.
  assign is_repeat = (rng_data == last_word);
  assign ptr_after = (pick_index == PW'(NREQ - 1)) ? '0 : pick_index + PW'(1);

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= RESET_STATE;
    else          state <= state_next;
  end

  // Next state: the warm-up ends on its last advance, and any repeated word is fatal.
  always_comb begin
    state_next = state;
    case (state)
      ST_WARMUP: begin
        if (is_repeat)                state_next = ST_FAIL;
        else if (warm_cnt <= CW'(1))  state_next = ST_RUN;
      end
      ST_RUN: begin
        if (pick_any && is_repeat)    state_next = ST_FAIL;
      end
      ST_FAIL:   state_next = ST_FAIL;
      default:   state_next = RESET_STATE;
    endcase
  end

  // Advance and delivery decisions. The source is held still while in reset.
  always_comb begin
    rng_enable = 1'b0;
    deliver    = 1'b0;
    if (reset_n) begin
      case (state)
        ST_WARMUP: rng_enable = 1'b1;
        ST_RUN: begin
          rng_enable = pick_any;
          deliver    = pick_any && !is_repeat;
        end
        default: ;
      endcase
    end
  end

  // Warm-up counter, round-robin pointer and last consumed word.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      warm_cnt  <= WARM_INIT;
      ptr       <= '0;
      last_word <= '0;
    end else begin
      if (rng_enable) last_word <= rng_data;
      if (state == ST_WARMUP && rng_enable && warm_cnt != '0) warm_cnt <= warm_cnt - CW'(1);
      if (deliver) ptr <= ptr_after;
    end
  end

  // Registered response and status outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rsp_valid <= '0;
      rsp_data  <= '0;
      ready     <= 1'b0;
      error     <= 1'b0;
    end else begin
      rsp_valid <= deliver ? grant : '0;
      if (deliver) rsp_data <= rng_data;
      ready     <= (state_next == ST_RUN);
      error     <= (state_next == ST_FAIL);
    end
  end

endmodule

// File: tb/tb_rng_arbiter.sv
// Randomised and directed bench for rng_arbiter against a behavioural model.
module tb_rng_arbiter;
  import rng_arb_pkg::*;

  localparam int NREQ   = 4;
  localparam int DBITS  = 64;
  localparam int WARMUP = 4;

  logic             clock = 1'b0;
  logic             reset_n = 1'b0;
  logic [DBITS-1:0] rng_data;
  logic             rng_enable;
  logic [NREQ-1:0]  req = '0;
  logic [NREQ-1:0]  rsp_valid;
  logic [DBITS-1:0] rsp_data;
  logic             ready;
  logic             error;

  logic [63:0] lfsr = '1;
  bit          src_force = 1'b0;

  int total = 0;
  int bad   = 0;

  int          m_phase;
  int          m_warm;
  int          m_ptr;
  logic [63:0] m_last;
  bit          seen [logic [63:0]];

  rng_arbiter #(
    .NREQ   (NREQ),
    .DBITS  (DBITS),
    .WARMUP (WARMUP)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .rng_data   (rng_data),
    .rng_enable (rng_enable),
    .req        (req),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .ready      (ready),
    .error      (error)
  );

  // Free-running clock.
  always #5 clock = ~clock;

  function automatic logic [63:0] lfsr_step(input logic [63:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
  endfunction

  // Behavioural source: advances only when the arbiter consumes a word.
  assign rng_data = src_force ? 64'h5 : lfsr;
  always @(posedge clock) if (rng_enable) lfsr <= lfsr_step(lfsr);

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = 0;
    m_warm  = WARMUP;
    m_ptr   = 0;
    m_last  = '0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rng_enable"}, rng_enable, 0);
    check({tag, "_rsp_valid"},  rsp_valid,  0);
    check({tag, "_rsp_data"},   rsp_data,   0);
    check({tag, "_ready"},      ready,      0);
    check({tag, "_error"},      error,      0);
  endtask

  // One clock cycle: drive, predict, check the advance, clock, check results.
  task automatic cycle(input logic [3:0] r, input bit frc);
    logic [63:0] word;
    logic [63:0] ed;
    logic [3:0]  ev;
    bit          en;
    int          w;
    int          idx;
    req = r;
    src_force = frc;
    #1;
    word = rng_data;
    en = 1'b0;
    ev = '0;
    ed = '0;
    case (m_phase)
      0: begin
        en = 1'b1;
        if (word == m_last) m_phase = 2;
        else begin
          m_warm--;
          if (m_warm == 0) m_phase = 1;
        end
        m_last = word;
      end
      1: begin
        if (r != 0) begin
          en = 1'b1;
          w = -1;
          for (int k = 0; k < NREQ; k++) begin
            idx = (m_ptr + k) % NREQ;
            if (w < 0 && ((r >> idx) & 4'b0001) != 4'b0000) w = idx;
          end
          if (word == m_last) m_phase = 2;
          else begin
            ev = 4'b0001 << w;
            ed = word;
            m_ptr = (w + 1) % NREQ;
          end
          m_last = word;
        end
      end
      default: ;
    endcase
    check("rng_enable", rng_enable, en);
    @(posedge clock);
    #1;
    check("rsp_valid", rsp_valid, ev);
    if (ev != 0) begin
      check("rsp_data", rsp_data, ed);
      check("no_repeat_delivery", seen.exists(rsp_data), 0);
      seen[rsp_data] = 1'b1;
    end
    check("ready", ready, m_phase == 1);
    check("error", error, m_phase == 2);
    @(negedge clock);
  endtask

  // Mid-cycle asynchronous reset pulse; outputs must clear immediately.
  task automatic pulse_reset(input logic [3:0] r);
    req = r;
    src_force = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    @(negedge clock);
    reset_n = 1'b1;
    model_reset();
  endtask

  initial begin
    model_reset();
    #2;
    check_all_zero("por");
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;

    for (int i = 0; i < WARMUP + 2; i++) cycle(4'b0000, 1'b0);
    for (int i = 0; i < 6; i++) cycle(4'b0001, 1'b0);
    for (int i = 0; i < 8; i++) cycle(4'b1111, 1'b0);
    for (int i = 0; i < 40; i++) cycle(4'($urandom_range(0, 15)), 1'b0);

    pulse_reset(4'b1111);
    for (int i = 0; i < WARMUP + 8; i++) cycle(4'b1111, 1'b0);

    pulse_reset(4'b0100);
    for (int i = 0; i < WARMUP + 1; i++) cycle(4'b0100, 1'b0);
    for (int i = 0; i < 4; i++) cycle(4'b1111, 1'b0);
    for (int i = 0; i < 30; i++) cycle(4'($urandom_range(0, 15)), 1'b0);

    cycle(4'b0010, 1'b1);
    cycle(4'b0010, 1'b1);
    for (int i = 0; i < 3; i++) cycle(4'b1111, 1'b1);
    for (int i = 0; i < 2; i++) cycle(4'b1111, 1'b0);

    pulse_reset(4'b0000);
    for (int i = 0; i < WARMUP; i++) cycle(4'b0000, 1'b0);
    for (int i = 0; i < 20; i++) cycle(4'($urandom_range(0, 15)), 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
